// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter feeding the deserializer stage.
// A legal request loads a W-bit word and a bit count; the top N bits are then
// shifted out MSB-first, one per clock, each qualified by ser_data_val_o.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no word in flight; shift register and counter held at zero
// SEND  | shifting; counter holds the number of bits still to present
module bit_serializer #(
    parameter int W     = 16,
    parameter int MOD_W = $clog2(W + 1)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [W-1:0]     data_i,
    input  logic [MOD_W-1:0] data_mod_i,
    input  logic             data_val_i,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             busy_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [MOD_W-1:0] MOD_MIN  = MOD_W'(3);
    localparam logic [MOD_W-1:0] MOD_FULL = MOD_W'(W);
    localparam logic [MOD_W-1:0] CNT_ONE  = MOD_W'(1);

    state_t           state_q;
    logic [W-1:0]     shift_q;
    logic [MOD_W-1:0] cnt_q;

    logic             mod_legal;
    logic [MOD_W-1:0] len_d;

    // Decode the requested length; 1, 2 and anything above W are rejected.
    always_comb begin
        mod_legal = 1'b0;
        len_d     = '0;
        if (data_mod_i == '0) begin
            mod_legal = 1'b1;
            len_d     = MOD_FULL;
        end else if ((data_mod_i >= MOD_MIN) && (data_mod_i <= MOD_FULL)) begin
            mod_legal = 1'b1;
            len_d     = data_mod_i;
        end
    end

    // Sequencer: accept a word in IDLE, shift it out MSB-first in SEND.
    // The counter counts the bit currently on the output, so leaving SEND
    // on count 1 yields exactly N valid cycles.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_val_i && mod_legal) begin
                        state_q <= SEND;
                        shift_q <= data_i;
                        cnt_q   <= len_d;
                    end
                end
                SEND: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= IDLE;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end else begin
                        shift_q <= {shift_q[W-2:0], 1'b0};
                        cnt_q   <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    shift_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; shift_q is zero whenever IDLE,
    // so the data line rests low between words.
    always_comb begin
        ser_data_o     = shift_q[W-1];
        ser_data_val_o = (state_q == SEND);
        busy_o         = (state_q == SEND);
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial converter that sits directly upstream of the deserializer stage.
- Accepts a W-bit word with a bit count and shifts the selected bits out MSB-first on a 1-bit stream.
- Each output bit is qualified by a valid strobe, so the output pair connects to the deserializer's data_i/data_val_i.
- Reports busy while a word is in flight.

Parameters:
- W, 16, parallel word width in bits (W >= 3).
- MOD_W, $clog2(W+1), width of the bit-count input.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- srst_i  input  1  reset, asynchronous, active-high.
- data_i  input  W  parallel word; bit W-1 is transmitted first.
- data_mod_i  input  MOD_W  number of bits to send from data_i[W-1] downward; 0 means all W bits.
- data_val_i  input  1  request strobe; data_i/data_mod_i sampled when high and busy_o low.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o valid this cycle.
- busy_o  output  1  transmission in progress; new requests ignored.

Behaviour:
- Reset: async assertion immediately forces ser_data_o=0, ser_data_val_o=0, busy_o=0. Shift register and counter clear, state=IDLE. Any word in flight is aborted and never resumed. Release is taken at a clock edge.
- Effective length N: N=W if data_mod_i==0; N=data_mod_i if 3<=data_mod_i<=W. data_mod_i of 1, 2, or >W means the request is dropped: no state change, no output.
- FSM has two states:
  - IDLE: ser_data_val_o=0, busy_o=0, ser_data_o=0. On a rising edge with data_val_i=1 and a legal N, latch data_i into the shift register, load counter=N, go to SEND.
  - SEND: ser_data_val_o=1, busy_o=1, ser_data_o=shift_reg[W-1]. Each edge shifts left by one (LSB filled with 0) and decrements the counter. When counter==1 at the edge, go to IDLE.
- Latency: first bit appears on the cycle after the accepting edge. Output is exactly N consecutive valid cycles with no gaps.
- Outputs are registered; no combinational path from inputs to outputs.
- data_val_i while busy_o=1 is ignored. data_i/data_mod_i changes during SEND have no effect on the stream.
- Back-to-back: a new request can be accepted in the first IDLE cycle after the last bit. Minimum 1 idle cycle between words (ser_data_val_o low for at least one cycle).
- Counter width MOD_W; never wraps. Counter is 0 in IDLE.
- busy_o == ser_data_val_o at all times. Both are derived from state.

Test Plan:
- W=16, data_i=16'hA5C3, data_mod_i=0, one-cycle data_val_i -> next 16 cycles ser_data_val_o=1, ser_data_o=1010010111000011, busy_o=1; then both low.
- data_i=16'hB800, data_mod_i=5 -> 5 valid cycles carrying 1,0,1,1,1; busy_o deasserts after the 5th bit.
- data_mod_i=1, then 2, then 17, each with data_val_i=1 -> ser_data_val_o and busy_o stay 0 for 20 cycles.
- Start 16'hFFFF (mod 0); on bit 4 drive data_val_i=1 with 16'h0000 -> stream stays all ones for 16 bits; second request is not transmitted.
- Start 16'h1234 (mod 0); assert srst_i mid-cycle during bit 7 -> outputs go 0 before the next edge. After release, idle until the next request, which then transmits fully and correctly.
- Chain into the deserializer (W=16) and send 16'h0000..16'h00FF back-to-back at maximum rate -> every deser_data_o equals the sent word and no word is lost.
